contador_run_ctrl: RTL and testbench

- Run/pause/clear sequencer for the 4-digit BCD counter chain (digits 3..0, terminal count 9675).
- Debounces two raw push-buttons and gates the per-tick count enable into digit 0 (ena0in).
- Issues the clear pulse into the digit controller (rstbutton) and stops the chain at the limit value, or wraps it.
- Sits between board buttons, the clock divider's tick and the counter controller; single clock domain.

---
 rtl/contador_run_ctrl.sv | 127 ++++++++++++
 tb/tb_contador_run_ctrl.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/contador_run_ctrl.sv
// Run/pause/clear sequencer for the 4-digit BCD counter chain: debounced buttons,
// gated count enable into digit 0, clear pulse, and stop-or-wrap at the limit value.

module contador_run_ctrl_deb #(
    parameter int DEB_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_i,
    output logic press_o
);
    localparam int            CW      = $clog2(DEB_CYCLES) + 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEB_CYCLES - 1);

    logic          s1_q, s2_q;
    logic          stable_q, stable_d, stable_prev_q;
    logic [CW-1:0] cnt_q, cnt_d;

    // Counter runs only while the synced level disagrees with the accepted one.
    always_comb begin
        cnt_d    = '0;
        stable_d = stable_q;
        if (s2_q != stable_q) begin
            if (cnt_q == CNT_MAX) stable_d = s2_q;
            else                  cnt_d    = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_q          <= 1'b0;
            s2_q          <= 1'b0;
            stable_q      <= 1'b0;
            stable_prev_q <= 1'b0;
            cnt_q         <= '0;
        end else begin
            s1_q          <= btn_i;
            s2_q          <= s1_q;
            stable_q      <= stable_d;
            stable_prev_q <= stable_q;
            cnt_q         <= cnt_d;
        end
    end

    assign press_o = stable_q & ~stable_prev_q;
endmodule

module contador_run_ctrl #(
    parameter int DEB_CYCLES = 16,
    parameter int LIMIT3     = 9,
    parameter int LIMIT2     = 6,
    parameter int LIMIT1     = 7,
    parameter int LIMIT0     = 5,
    parameter int AUTO_WRAP  = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_start_stop,
    input  logic       btn_clear,
    input  logic       tick,
    input  logic [3:0] Qdata3,
    input  logic [3:0] Qdata2,
    input  logic [3:0] Qdata1,
    input  logic [3:0] Qdata0,
    output logic       ena0_out,
    output logic       clr_out,
    output logic [1:0] state_out,
    output logic       at_limit
);
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        PAUSE = 2'b10,
        DONE  = 2'b11
    } state_e;

    localparam logic [15:0] LIMIT = {4'(LIMIT3), 4'(LIMIT2), 4'(LIMIT1), 4'(LIMIT0)};

    state_e     state_q;
    logic       clr_q;
    logic [1:0] btn_raw, press;   // [0] start/stop, [1] clear

    assign btn_raw = {btn_clear, btn_start_stop};

    genvar b;
    generate
        for (b = 0; b < 2; b++) begin : g_deb
            contador_run_ctrl_deb #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
                .clk    (clk),
                .rst    (rst),
                .btn_i  (btn_raw[b]),
                .press_o(press[b])
            );
        end
    endgenerate

    assign at_limit = ({Qdata3, Qdata2, Qdata1, Qdata0} == LIMIT);

    // Priority clear > start > limit. A clear right after a wrap pulse still
    // returns to IDLE but does not re-pulse the already-cleared counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            clr_q   <= 1'b0;
        end else begin
            clr_q <= 1'b0;
            if (press[1]) begin
                state_q <= IDLE;
                clr_q   <= ~clr_q;
            end else if (press[0]) begin
                case (state_q)
                    IDLE:    state_q <= RUN;
                    RUN:     state_q <= PAUSE;
                    PAUSE:   state_q <= RUN;
                    default: state_q <= state_q;
                endcase
            end else if (state_q == RUN && at_limit) begin
                if (AUTO_WRAP == 0)     state_q <= DONE;
                else if (tick && !clr_q) clr_q  <= 1'b1;
            end
        end
    end

    assign state_out = state_q;
    assign clr_out   = clr_q;
    assign ena0_out  = (state_q == RUN) & tick & ~at_limit & ~clr_q;
endmodule

// File: tb/tb_contador_run_ctrl.sv
// Bench for contador_run_ctrl: stop (dut0) and wrap (dut1) variants driven in parallel
// and compared against a window-based button model and a priority-rule FSM model.
`timescale 1ns/1ps
module tb_contador_run_ctrl;
    localparam int DEB = 4;

    logic       clk = 1'b0, rst = 1'b1, bs = 1'b0, bc = 1'b0, tick = 1'b0;
    logic [3:0] q3 = '0, q2 = '0, q1 = '0, q0 = '0;
    logic       ena0, clr0, lim0, ena1, clr1, lim1;
    logic [1:0] st0, st1;
    logic [4:0] act0, act1;
    int         nvec = 0, nerr = 0;

    contador_run_ctrl #(.DEB_CYCLES(DEB), .AUTO_WRAP(0)) dut0 (
        .clk(clk), .rst(rst), .btn_start_stop(bs), .btn_clear(bc), .tick(tick),
        .Qdata3(q3), .Qdata2(q2), .Qdata1(q1), .Qdata0(q0),
        .ena0_out(ena0), .clr_out(clr0), .state_out(st0), .at_limit(lim0));

    contador_run_ctrl #(.DEB_CYCLES(DEB), .AUTO_WRAP(1)) dut1 (
        .clk(clk), .rst(rst), .btn_start_stop(bs), .btn_clear(bc), .tick(tick),
        .Qdata3(q3), .Qdata2(q2), .Qdata1(q1), .Qdata0(q0),
        .ena0_out(ena1), .clr_out(clr1), .state_out(st1), .at_limit(lim1));

    assign act0 = {st0, clr0, ena0, lim0};
    assign act1 = {st1, clr1, ena1, lim1};

    always #5 clk = ~clk;

    // Reference model: states 0=IDLE 1=RUN 2=PAUSE 3=DONE; index 0 stop, 1 wrap.
    int        m_st [2];
    bit        m_clr [2];
    bit        r1 [2], r2 [2], stab [2], pend [2];
    bit [63:0] h [2];
    int        ns;
    bit        nc;
    bit [1:0]  raw;

    function automatic bit m_lim();
        return {q3, q2, q1, q0} == 16'h9675;
    endfunction

    function automatic logic [4:0] exp_vec(int w);
        bit l;
        l = m_lim();
        return {2'(m_st[w]), m_clr[w], (m_st[w] == 1) && tick && !l && !m_clr[w], l};
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 2; i++) begin
                m_st[i] = 0; m_clr[i] = 0; r1[i] = 0; r2[i] = 0;
                stab[i] = 0; pend[i] = 0; h[i] = '0;
            end
        end else begin
            for (int w = 0; w < 2; w++) begin
                ns = m_st[w];
                nc = 1'b0;
                if (pend[1]) begin
                    ns = 0;
                    nc = !m_clr[w];
                end else if (pend[0]) begin
                    if (m_st[w] == 0 || m_st[w] == 2) ns = 1;
                    else if (m_st[w] == 1)            ns = 2;
                end else if (m_st[w] == 1 && m_lim()) begin
                    if (w == 0) ns = 3;
                    else if (tick && !m_clr[w]) nc = 1'b1;
                end
                m_st[w]  = ns;
                m_clr[w] = nc;
            end
            raw = {bc, bs};
            for (int b = 0; b < 2; b++) begin
                // A level is accepted once the last DEB synced samples all disagree with it.
                h[b]    = {h[b][62:0], r2[b]};
                pend[b] = 1'b0;
                if (h[b][DEB-1:0] == {DEB{~stab[b]}}) begin
                    stab[b] = ~stab[b];
                    pend[b] = stab[b];
                end
                r2[b] = r1[b];
                r1[b] = raw[b];
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wait_cycles(int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic do_reset();
        rst = 1'b0; bs = 1'b0; bc = 1'b0; tick = 1'b0;
        {q3, q2, q1, q0} = '0;
        wait_cycles(2);
        rst = 1'b1;
    endtask

    // which: 0 start, 1 clear, 2 both
    task automatic press(int which, int hold);
        if (which != 1) bs = 1'b1;
        if (which != 0) bc = 1'b1;
        wait_cycles(hold);
        bs = 1'b0; bc = 1'b0;
        wait_cycles(DEB + 4);
    endtask

    task automatic test_reset();
        rst = 1'b0; bs = 1'b0; bc = 1'b0; tick = 1'b0;
        {q3, q2, q1, q0} = '0;
        #2;
        nvec++;
        if (act0 !== 5'b0 || act1 !== 5'b0) begin
            nerr++; $display("FAIL reset_state act0=%b act1=%b exp=00000", act0, act1);
        end
        wait_cycles(2);
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cyc();
            nvec++;
            if (act0 !== 5'b0 || act1 !== exp_vec(1)) begin
                nerr++; $display("FAIL reset_idle act0=%b act1=%b exp=00000", act0, act1);
            end
        end
    endtask

    task automatic test_start_latency();
        do_reset();
        bs = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            cyc();
            nvec++;
            if (st0 !== ((k >= 7) ? 2'b01 : 2'b00)) begin
                nerr++; $display("FAIL start_latency edge=%0d act=%b exp=%b", k, st0, (k >= 7) ? 2'b01 : 2'b00);
            end
        end
        bs = 1'b0;
        for (int k = 0; k < 12; k++) begin
            cyc();
            nvec++;
            if (st0 !== 2'b01 || act1 !== exp_vec(1)) begin
                nerr++; $display("FAIL start_single_event st0=%b act1=%b exp1=%b", st0, act1, exp_vec(1));
            end
        end
    endtask

    task automatic test_tick_gating();
        int phase;
        do_reset();
        press(0, DEB + 4);
        phase = $urandom_range(0, 4);
        for (int k = 0; k < 40; k++) begin
            tick = ((k % 5) == phase);
            if (k >= 20) {q3, q2, q1, q0} = {4'($urandom_range(0, 8)), 4'($urandom_range(0, 9)),
                                             4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
            cyc();
            nvec++;
            if (ena0 !== tick || ena1 !== tick || act0 !== exp_vec(0)) begin
                nerr++; $display("FAIL tick_gate k=%0d ena0=%b ena1=%b exp=%b act0=%b", k, ena0, ena1, tick, act0);
            end
        end
        tick = 1'b0;
        bs = 1'b1;
        wait_cycles(3);
        bs = 1'b0;
        for (int k = 0; k < 12; k++) begin
            cyc();
            nvec++;
            if (st0 !== 2'b01 || st1 !== 2'b01) begin
                nerr++; $display("FAIL glitch_ignored st0=%b st1=%b exp=01", st0, st1);
            end
        end
    endtask

    task automatic test_limit_done();
        int pulses;
        do_reset();
        press(0, DEB + 3);
        {q3, q2, q1, q0} = 16'h9675;
        tick = 1'b1;
        #1;
        nvec++;
        if (ena0 !== 1'b0 || ena1 !== 1'b0 || lim0 !== 1'b1 || lim1 !== 1'b1) begin
            nerr++; $display("FAIL limit_comb ena0=%b ena1=%b lim0=%b lim1=%b exp=0 0 1 1", ena0, ena1, lim0, lim1);
        end
        cyc();
        nvec++;
        if (st0 !== 2'b11 || st1 !== 2'b01 || clr1 !== 1'b1 || ena1 !== 1'b0 || clr0 !== 1'b0) begin
            nerr++; $display("FAIL limit_edge st0=%b st1=%b clr1=%b ena1=%b exp=11 01 1 0", st0, st1, clr1, ena1);
        end
        tick = 1'b0;
        cyc();
        nvec++;
        if (clr1 !== 1'b0 || st1 !== 2'b01) begin
            nerr++; $display("FAIL wrap_one_cycle clr1=%b st1=%b exp=0 01", clr1, st1);
        end
        {q3, q2, q1, q0} = '0;
        press(0, DEB + 2);
        nvec++;
        if (st0 !== 2'b11 || act1 !== exp_vec(1)) begin
            nerr++; $display("FAIL done_ignores_start st0=%b exp=11 act1=%b exp1=%b", st0, act1, exp_vec(1));
        end
        pulses = 0;
        bc = 1'b1;
        for (int k = 0; k < 14; k++) begin
            cyc();
            pulses += clr0;
            nvec++;
            if (act0 !== exp_vec(0) || act1 !== exp_vec(1)) begin
                nerr++; $display("FAIL done_clear k=%0d act0=%b exp0=%b act1=%b exp1=%b", k, act0, exp_vec(0), act1, exp_vec(1));
            end
            if (k == 6) bc = 1'b0;
        end
        nvec++;
        if (pulses != 1 || st0 !== 2'b00) begin
            nerr++; $display("FAIL done_clear_pulse pulses=%0d st0=%b exp=1 00", pulses, st0);
        end
    endtask

    task automatic test_clear_wins();
        int pulses;
        do_reset();
        press(0, DEB + 2);
        press(0, DEB + 2);
        nvec++;
        if (st0 !== 2'b10 || st1 !== 2'b10) begin
            nerr++; $display("FAIL pause_reach st0=%b st1=%b exp=10", st0, st1);
        end
        pulses = 0;
        bs = 1'b1; bc = 1'b1;
        for (int k = 0; k < 14; k++) begin
            cyc();
            pulses += clr0;
            nvec++;
            if (act0 !== exp_vec(0) || act1 !== exp_vec(1)) begin
                nerr++; $display("FAIL both_press k=%0d act0=%b exp0=%b act1=%b exp1=%b", k, act0, exp_vec(0), act1, exp_vec(1));
            end
            if (k == 7) begin bs = 1'b0; bc = 1'b0; end
        end
        nvec++;
        if (pulses != 1 || st0 !== 2'b00 || st1 !== 2'b00) begin
            nerr++; $display("FAIL clear_wins pulses=%0d st0=%b st1=%b exp=1 00 00", pulses, st0, st1);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        press(0, DEB + 2);
        tick = 1'b1;
        #2;
        rst = 1'b0;
        #1;
        nvec++;
        if (st0 !== 2'b00 || clr0 !== 1'b0 || ena0 !== 1'b0 || st1 !== 2'b00 || clr1 !== 1'b0) begin
            nerr++; $display("FAIL async_reset st0=%b clr0=%b ena0=%b st1=%b exp=00 0 0 00", st0, clr0, ena0, st1);
        end
        @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < 20; k++) begin
            cyc();
            nvec++;
            if (ena0 !== 1'b0 || ena1 !== 1'b0 || st0 !== 2'b00) begin
                nerr++; $display("FAIL inhibit_after_reset ena0=%b ena1=%b st0=%b exp=0 0 00", ena0, ena1, st0);
            end
        end
        bs = 1'b1;
        for (int k = 0; k < 12; k++) begin
            cyc();
            nvec++;
            if (act0 !== exp_vec(0) || act1 !== exp_vec(1)) begin
                nerr++; $display("FAIL restart k=%0d act0=%b exp0=%b act1=%b exp1=%b", k, act0, exp_vec(0), act1, exp_vec(1));
            end
        end
        bs = 1'b0;
        tick = 1'b0;
    endtask

    task automatic test_random();
        int hs, hc;
        bit rel;
        do_reset();
        hs = 0; hc = 0; rel = 1'b0;
        for (int k = 0; k < 3000; k++) begin
            cyc();
            nvec++;
            if (act0 !== exp_vec(0) || act1 !== exp_vec(1)) begin
                nerr++; $display("FAIL random k=%0d act0=%b exp0=%b act1=%b exp1=%b", k, act0, exp_vec(0), act1, exp_vec(1));
            end
            if (rel) begin rst = 1'b1; rel = 1'b0; end
            else if ($urandom_range(0, 499) == 0) begin rst = 1'b0; rel = 1'b1; end
            if (hs == 0) begin bs = ($urandom_range(0, 2) == 0); hs = $urandom_range(1, 3 * DEB); end
            else hs--;
            if (hc == 0) begin bc = ($urandom_range(0, 5) == 0); hc = $urandom_range(1, 3 * DEB); end
            else hc--;
            tick = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 5) == 0) {q3, q2, q1, q0} = 16'h9675;
            else {q3, q2, q1, q0} = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)),
                                     4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_start_latency();
        test_tick_gating();
        test_limit_done();
        test_clear_wins();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
